// File: rtl/maxpool_win_addr_gen_if.sv
// Address stream from the pooling-window generator to the max-pool compare datapath.
// The generator drives the master side and the consumer drives the slave side.
interface maxpool_win_addr_gen_if #(
  parameter int ADDR_W = 24
);
  logic [ADDR_W-1:0] addr_out;
  logic              addr_valid;
  logic              addr_ready;
  logic              win_last;
  logic              frame_done;

  modport master (
    output addr_out,
    output addr_valid,
    output win_last,
    output frame_done,
    input  addr_ready
  );

  modport slave (
    input  addr_out,
    input  addr_valid,
    input  win_last,
    input  frame_done,
    output addr_ready
  );
endinterface

// File: rtl/maxpool_win_addr_gen.sv
// Walks every output pixel of a frame and streams the K x K line-buffer addresses of its
// pooling window (row * in_w + col) through a registered multiply pipeline.
module maxpool_win_addr_gen #(
  parameter int ROW_W   = 16,
  parameter int LW_W    = 8,
  parameter int ADDR_W  = 24,
  parameter int MUL_LAT = 4
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              start,
  input  logic [7:0]        cfg_out_h,
  input  logic [7:0]        cfg_out_w,
  input  logic [LW_W-1:0]   cfg_in_w,
  input  logic [1:0]        cfg_k,
  input  logic [1:0]        cfg_stride,
  output logic              busy,
  maxpool_win_addr_gen_if.master st
);
  // The issue register doubles as the multiplier operand stage, leaving DL product stages.
  localparam int DL = MUL_LAT - 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t state_r, state_nx_s;
  logic [7:0]        out_h_r, out_w_r, oy_r, ox_r;
  logic [LW_W-1:0]   in_w_r;
  logic [1:0]        k_r, s_r, ky_r, kx_r;
  logic              ce_s, issue_s, drain_exit_s, pipe_empty_s, last_hs_s;
  logic              kx_end_s, ky_end_s, ox_end_s, oy_end_s, frame_end_s;
  logic [ROW_W-1:0]  row_nx_s, col_nx_s;

  logic              v1_r, wl1_r, fl1_r;
  logic [ROW_W-1:0]  row_r, col_r;
  logic [ADDR_W-1:0] prod_r [0:DL-1];
  logic [ROW_W-1:0]  dcol_r [0:DL-1];
  logic [DL-1:0]     dv_r, dwl_r, dfl_r;
  logic [ADDR_W-1:0] addr_out_r;
  logic              addr_valid_r, win_last_r, flast_r, frame_done_r, busy_r;

  // Stall enable, window/frame position decode and row/col of the index being issued.
  always_comb begin
    ce_s         = !(addr_valid_r && !st.addr_ready);
    kx_end_s     = (kx_r == (k_r - 2'd1));
    ky_end_s     = (ky_r == (k_r - 2'd1));
    ox_end_s     = (ox_r == (out_w_r - 8'd1));
    oy_end_s     = (oy_r == (out_h_r - 8'd1));
    frame_end_s  = kx_end_s && ky_end_s && ox_end_s && oy_end_s;
    row_nx_s     = ROW_W'(oy_r) * ROW_W'(s_r) + ROW_W'(ky_r);
    col_nx_s     = ROW_W'(ox_r) * ROW_W'(s_r) + ROW_W'(kx_r);
    pipe_empty_s = !v1_r && !(|dv_r) && !addr_valid_r;
    last_hs_s    = addr_valid_r && st.addr_ready && flast_r;
  end

  // FSM state register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic; an empty frame goes straight to DRAIN.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if ((cfg_out_h == 8'd0) || (cfg_out_w == 8'd0)) begin
            state_nx_s = DRAIN;
          end else begin
            state_nx_s = RUN;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (issue_s && frame_end_s) begin
          state_nx_s = DRAIN;
        end else begin
          state_nx_s = RUN;
        end
      end
      DRAIN: begin
        if (last_hs_s || pipe_empty_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DRAIN;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM outputs: issue strobe and end-of-frame detection.
  always_comb begin
    issue_s      = 1'b0;
    drain_exit_s = 1'b0;
    case (state_r)
      RUN:     issue_s      = ce_s;
      DRAIN:   drain_exit_s = (state_nx_s == IDLE);
      default: begin
        issue_s      = 1'b0;
        drain_exit_s = 1'b0;
      end
    endcase
  end

  // Shadow config and nested oy/ox/ky/kx issue counters.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_h_r <= 8'd0;
      out_w_r <= 8'd0;
      in_w_r  <= '0;
      k_r     <= 2'd1;
      s_r     <= 2'd1;
      oy_r    <= 8'd0;
      ox_r    <= 8'd0;
      ky_r    <= 2'd0;
      kx_r    <= 2'd0;
    end else if ((state_r == IDLE) && start) begin
      out_h_r <= cfg_out_h;
      out_w_r <= cfg_out_w;
      in_w_r  <= cfg_in_w;
      k_r     <= (cfg_k == 2'd0) ? 2'd1 : cfg_k;
      s_r     <= (cfg_stride == 2'd0) ? 2'd1 : cfg_stride;
      oy_r    <= 8'd0;
      ox_r    <= 8'd0;
      ky_r    <= 2'd0;
      kx_r    <= 2'd0;
    end else if (issue_s) begin
      if (kx_end_s) begin
        kx_r <= 2'd0;
        if (ky_end_s) begin
          ky_r <= 2'd0;
          if (ox_end_s) begin
            ox_r <= 8'd0;
            oy_r <= oy_r + 8'd1;
          end else begin
            ox_r <= ox_r + 8'd1;
          end
        end else begin
          ky_r <= ky_r + 2'd1;
        end
      end else begin
        kx_r <= kx_r + 2'd1;
      end
    end else begin
      kx_r <= kx_r;
    end
  end

  // Issue stage, product pipeline with matched col/flag delay line, and registered add.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      v1_r         <= 1'b0;
      wl1_r        <= 1'b0;
      fl1_r        <= 1'b0;
      row_r        <= '0;
      col_r        <= '0;
      dv_r         <= '0;
      dwl_r        <= '0;
      dfl_r        <= '0;
      addr_out_r   <= '0;
      addr_valid_r <= 1'b0;
      win_last_r   <= 1'b0;
      flast_r      <= 1'b0;
      for (int i = 0; i < DL; i++) begin
        prod_r[i] <= '0;
        dcol_r[i] <= '0;
      end
    end else if (ce_s) begin
      v1_r      <= issue_s;
      wl1_r     <= issue_s && kx_end_s && ky_end_s;
      fl1_r     <= issue_s && frame_end_s;
      row_r     <= row_nx_s;
      col_r     <= col_nx_s;
      prod_r[0] <= ADDR_W'(row_r) * ADDR_W'(in_w_r);
      dcol_r[0] <= col_r;
      dv_r[0]   <= v1_r;
      dwl_r[0]  <= wl1_r;
      dfl_r[0]  <= fl1_r;
      for (int i = 1; i < DL; i++) begin
        prod_r[i] <= prod_r[i-1];
        dcol_r[i] <= dcol_r[i-1];
        dv_r[i]   <= dv_r[i-1];
        dwl_r[i]  <= dwl_r[i-1];
        dfl_r[i]  <= dfl_r[i-1];
      end
      addr_out_r   <= prod_r[DL-1] + ADDR_W'(dcol_r[DL-1]);
      addr_valid_r <= dv_r[DL-1];
      win_last_r   <= dwl_r[DL-1];
      flast_r      <= dfl_r[DL-1];
    end else begin
      addr_valid_r <= addr_valid_r;
    end
  end

  // Frame-done pulse and busy flag.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      frame_done_r <= drain_exit_s;
      busy_r       <= (state_nx_s != IDLE);
    end
  end

  assign st.addr_out   = addr_out_r;
  assign st.addr_valid = addr_valid_r;
  assign st.win_last   = win_last_r;
  assign st.frame_done = frame_done_r;
  assign busy          = busy_r;
endmodule
